sh7604_bus_responder: RTL and testbench

SH7604_BUS_RESPONDER -- requirements
Module: sh7604_bus_responder

---
 rtl/sh7604_bus_responder_pkg.sv | 13 +
 rtl/sh7604_bus_responder_if.sv | 34 +++
 rtl/sh7604_bus_responder.sv | 124 ++++++++++++
 tb/tb_sh7604_bus_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sh7604_bus_responder_pkg.sv
// SH7604 bus responder shared types.
// FSM encoding and the read value returned on a memory timeout.
package sh7604_bus_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/sh7604_bus_responder_if.sv
// SH7604 external bus plus memory-side request bundle.
// master drives the CPU pins and memory response; slave is the responder.
interface sh7604_bus_responder_if #(
    parameter int ADDR_W = 24
);
    logic              ce_r;
    logic [26:0]       a;
    logic [31:0]       di;
    logic [31:0]       dout;
    logic              bs_n;
    logic              cs_n;
    logic              rd_wr_n;
    logic [3:0]        we_n;
    logic              wait_n;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_do;
    logic [3:0]        mem_be;
    logic              mem_we;
    logic              mem_req;
    logic [31:0]       mem_di;
    logic              mem_ack;
    logic              err;

    modport master (
        output ce_r, a, di, bs_n, cs_n, rd_wr_n, we_n, mem_di, mem_ack,
        input  dout, wait_n, mem_a, mem_do, mem_be, mem_we, mem_req, err
    );

    modport slave (
        input  ce_r, a, di, bs_n, cs_n, rd_wr_n, we_n, mem_di, mem_ack,
        output dout, wait_n, mem_a, mem_do, mem_be, mem_we, mem_req, err
    );

endinterface

// File: rtl/sh7604_bus_responder.sv
// Turns SH7604 external bus cycles into a req/ack memory transaction,
// stretching the CPU with WAIT_N and giving up after TIMEOUT updates.
module sh7604_bus_responder
    import sh7604_bus_responder_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic [26:0]       A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    input  logic              BS_N,
    input  logic              CS_N,
    input  logic              RD_WR_N,
    input  logic [3:0]        WE_N,
    output logic              WAIT_N,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [31:0]       MEM_DO,
    output logic [3:0]        MEM_BE,
    output logic              MEM_WE,
    output logic              MEM_REQ,
    input  logic [31:0]       MEM_DI,
    input  logic              MEM_ACK,
    output logic              ERR
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n, cnt_inc;
    logic [31:0]       dout_n;
    logic              wait_n_n, err_n, req_n, we_n_n;
    logic [ADDR_W-1:0] a_n;
    logic [31:0]       mdo_n;
    logic [3:0]        be_n;
    logic              start;
    logic              unused_addr;

    assign unused_addr = ^A[26:ADDR_W];
    assign cnt_inc     = cnt + 8'd1;
    assign start       = !BS_N && !CS_N;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            DO      <= '0;
            WAIT_N  <= 1'b1;
            ERR     <= 1'b0;
            MEM_REQ <= 1'b0;
            MEM_A   <= '0;
            MEM_DO  <= '0;
            MEM_BE  <= '0;
            MEM_WE  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            DO      <= dout_n;
            WAIT_N  <= wait_n_n;
            ERR     <= err_n;
            MEM_REQ <= req_n;
            MEM_A   <= a_n;
            MEM_DO  <= mdo_n;
            MEM_BE  <= be_n;
            MEM_WE  <= we_n_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dout_n   = DO;
        wait_n_n = WAIT_N;
        err_n    = ERR;
        req_n    = MEM_REQ;
        a_n      = MEM_A;
        mdo_n    = MEM_DO;
        be_n     = MEM_BE;
        we_n_n   = MEM_WE;
        if (CE_R) begin
            err_n = 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n  = REQ;
                        cnt_n    = '0;
                        req_n    = 1'b1;
                        wait_n_n = 1'b0;
                        a_n      = A[ADDR_W-1:0];
                        mdo_n    = DI;
                        we_n_n   = !RD_WR_N;
                        be_n     = RD_WR_N ? 4'hF : ~WE_N;
                    end else if (state == DONE && CS_N) begin
                        state_n = IDLE;
                    end
                end
                REQ: begin
                    // The raising update happened in IDLE/DONE, so any ack
                    // seen here is at least one update after the request.
                    if (MEM_ACK) begin
                        state_n  = DONE;
                        req_n    = 1'b0;
                        wait_n_n = 1'b1;
                        if (!MEM_WE) dout_n = MEM_DI;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == TIMEOUT_CNT) begin
                            state_n  = DONE;
                            req_n    = 1'b0;
                            wait_n_n = 1'b1;
                            err_n    = 1'b1;
                            if (!MEM_WE) dout_n = TIMEOUT_RDATA;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sh7604_bus_responder.sv
// Randomized scoreboard bench for the SH7604 bus responder.
// Driver queues expected requests/completions; a monitor checks them.
module tb_sh7604_bus_responder;
    import sh7604_bus_responder_pkg::*;

    localparam int ADDR_W = 24;
    localparam int TO     = 4;

    typedef struct {
        logic [23:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] dat;
        bit          b2b;
    } req_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          wcnt;
    } cmp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    req_t        rq[$];
    cmp_t        cq[$];
    logic [31:0] do_model = '0;
    bit          last_rst = 1'b1;

    sh7604_bus_responder_if #(.ADDR_W(ADDR_W)) bus ();

    sh7604_bus_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .CLK(clk), .RST(rst), .CE_R(bus.ce_r),
        .A(bus.a), .DI(bus.di), .DO(bus.dout),
        .BS_N(bus.bs_n), .CS_N(bus.cs_n), .RD_WR_N(bus.rd_wr_n),
        .WE_N(bus.we_n), .WAIT_N(bus.wait_n),
        .MEM_A(bus.mem_a), .MEM_DO(bus.mem_do), .MEM_BE(bus.mem_be),
        .MEM_WE(bus.mem_we), .MEM_REQ(bus.mem_req),
        .MEM_DI(bus.mem_di), .MEM_ACK(bus.mem_ack), .ERR(bus.err)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One qualified update, optionally preceded by a CE_R-low cycle.
    task automatic upd();
        int k;
        k = ($urandom_range(0, 2) == 0) ? 1 : 0;
        repeat (k) begin
            bus.ce_r = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        bus.ce_r = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic xact(bit rd, logic [26:0] a, logic [31:0] di,
                        logic [3:0] we_n, int d, logic [31:0] mdi,
                        bit b2b_in, bit rmid);
        int   n, r;
        bit   b2b;
        req_t e;
        cmp_t c;
        b2b = b2b_in && !last_rst;
        n   = (d <= TO) ? d : TO;
        if (!b2b) begin
            bus.cs_n = 1'b1;
            bus.bs_n = 1'($urandom);
            upd();
        end
        bus.bs_n    = 1'b0;
        bus.cs_n    = 1'b0;
        bus.a       = a;
        bus.di      = di;
        bus.rd_wr_n = rd;
        bus.we_n    = we_n;
        e.a   = a[23:0];
        e.be  = rd ? 4'hF : ~we_n;
        e.we  = !rd;
        e.dat = di;
        e.b2b = b2b;
        rq.push_back(e);
        if (!rmid) begin
            if (rd) do_model = (d <= TO) ? mdi : 32'hFFFF_FFFF;
            c.dat  = do_model;
            c.err  = (d > TO);
            c.wcnt = n + 1;
            cq.push_back(c);
        end
        upd();
        bus.bs_n    = 1'b1;
        bus.a       = 27'($urandom);
        bus.di      = $urandom;
        bus.we_n    = 4'($urandom);
        bus.rd_wr_n = 1'($urandom);
        if (rmid) begin
            r = $urandom_range(1, n);
            repeat (r - 1) upd();
            rst = 1'b1;
            upd();
            rst = 1'b0;
            bus.mem_ack = 1'b1;
            bus.mem_di  = $urandom;
            bus.cs_n    = 1'b1;
            upd();
            bus.mem_ack = 1'b0;
            do_model = '0;
            last_rst = 1'b1;
        end else begin
            for (int i = 1; i <= n; i++) begin
                if (i == d) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_di  = mdi;
                end else begin
                    bus.mem_di = $urandom;
                end
                upd();
                bus.mem_ack = 1'b0;
            end
            if (d > TO) begin
                bus.mem_ack = 1'b1;
                bus.mem_di  = $urandom;
                upd();
                bus.mem_ack = 1'b0;
            end
            last_rst = 1'b0;
        end
    endtask

    // Monitor: samples 1 ns after each edge; inputs change only on negedge.
    initial begin
        logic        p_req, p_wait, p_err;
        logic [31:0] p_do;
        bit          saw_idle, err_ok;
        int          wcnt;
        req_t        cap, e;
        cmp_t        c;
        p_req = 0; p_wait = 1; p_err = 0; p_do = '0;
        saw_idle = 1; err_ok = 0; wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_req", bus.mem_req, 0);
                chk("rst_wait", bus.wait_n, 1);
                chk("rst_err", bus.err, 0);
                chk("rst_do", bus.dout, 0);
                chk("rst_mem", {bus.mem_a, bus.mem_do, bus.mem_be, bus.mem_we}, 0);
                chk("rst_state", 64'(dut.state == IDLE), 1);
                p_req = 0; p_wait = 1; p_err = 0; p_do = '0;
                saw_idle = 1; err_ok = 0;
                continue;
            end
            if (!bus.ce_r) begin
                chk("ce_hold", {bus.mem_req, bus.wait_n, bus.err, bus.dout},
                    {p_req, p_wait, p_err, p_do});
                continue;
            end
            if (!p_req && bus.mem_req) begin
                if (rq.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    e = rq.pop_front();
                    chk("req_a", bus.mem_a, e.a);
                    chk("req_be", bus.mem_be, e.be);
                    chk("req_we", bus.mem_we, e.we);
                    chk("req_do", bus.mem_do, e.dat);
                    chk("req_wait", bus.wait_n, 0);
                    if (e.b2b) chk("b2b_no_idle", 64'(saw_idle), 0);
                    cap = e;
                end
                chk("req_err", bus.err, 0);
                chk("req_dout", bus.dout, p_do);
                wcnt = 1;
            end else if (p_req && bus.mem_req) begin
                chk("hold_mem", {bus.mem_a, bus.mem_be, bus.mem_we, bus.mem_do},
                    {cap.a, cap.be, cap.we, cap.dat});
                chk("hold_wait", bus.wait_n, 0);
                chk("hold_err", bus.err, 0);
                wcnt++;
            end else if (p_req && !bus.mem_req) begin
                wcnt++;
                if (cq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    c = cq.pop_front();
                    chk("done_do", bus.dout, c.dat);
                    chk("done_err", bus.err, c.err);
                    chk("done_wait", bus.wait_n, 1);
                    chk("wait_updates", wcnt, c.wcnt);
                end
                saw_idle = 0;
            end else begin
                chk("idle_do", bus.dout, p_do);
                chk("idle_err", bus.err, 0);
                chk("idle_wait", bus.wait_n, 1);
            end
            if (dut.state == IDLE) saw_idle = 1;
            err_ok = bus.err;
            p_req = bus.mem_req; p_wait = bus.wait_n;
            p_err = bus.err; p_do = bus.dout;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        bus.ce_r = 1'b0; bus.a = '0; bus.di = '0; bus.bs_n = 1'b1;
        bus.cs_n = 1'b1; bus.rd_wr_n = 1'b1; bus.we_n = 4'hF;
        bus.mem_di = '0; bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        xact(1, 27'h0001234, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 0, 0);
        xact(0, 27'h7ABCDEF, 32'h1122_3344, 4'b0011, 1, 32'h5555_AAAA, 0, 0);
        xact(1, 27'h0000010, 32'h0, 4'hF, 6, 32'h0BAD_0BAD, 0, 0);
        xact(1, 27'h0000020, 32'h0, 4'hF, 1, 32'hCAFE_0001, 0, 0);
        xact(1, 27'h0000024, 32'h0, 4'hF, 3, 32'hCAFE_0002, 1, 0);
        xact(0, 27'h0000028, 32'h9999_8888, 4'hF, 2, 32'h0, 1, 0);
        xact(1, 27'h0000030, 32'h0, 4'hF, 3, 32'h1357_9BDF, 0, 1);
        xact(1, 27'h0000040, 32'h0, 4'hF, TO, 32'hC011_1DE5, 0, 0);
        xact(0, 27'h0000044, 32'hAAAA_5555, 4'b1010, 6, 32'h0, 1, 0);
        for (int i = 0; i < 60; i++) begin
            xact(1'($urandom), 27'($urandom), $urandom, 4'($urandom),
                 $urandom_range(1, TO + 2), $urandom,
                 1'($urandom), $urandom_range(0, 11) == 0);
        end
        bus.cs_n = 1'b1;
        repeat (3) upd();
        w = 0;
        while ((rq.size() != 0 || cq.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("queues_drained", 64'(rq.size() + cq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
